// File: rtl/mole_host_responder.sv
// Hardware stand-in for the PC side of the whack-a-mole UART link: starts games with 'S' and answers moles with 'H'.
// Define AUTO_RESTART_EN to restart a finished game automatically after RESTART_CYCLES clocks.
module mole_host_responder #(
    parameter int unsigned REACT_CYCLES   = 25_000_000,
    parameter int unsigned RESTART_CYCLES = 200_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_req,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [2:0] mole_pos,
    output logic       mole_valid,
    output logic [7:0] hits_sent,
    output logic       game_running,
    output logic       game_over,
    output logic       bad_byte
);

    localparam int RW = (REACT_CYCLES > 1) ? $clog2(REACT_CYCLES) : 1;
    localparam logic [RW-1:0] REACT_LOAD = RW'(REACT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SEND_START = 3'd1;
    localparam logic [2:0] ST_WAIT_MOLE  = 3'd2;
    localparam logic [2:0] ST_REACT      = 3'd3;
    localparam logic [2:0] ST_SEND_HIT   = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;

    localparam logic [7:0] BYTE_START = 8'h53;
    localparam logic [7:0] BYTE_HIT   = 8'h48;
    localparam logic [7:0] BYTE_OVER  = 8'h52;

    logic [2:0]    state_q, state_d;
    logic [RW-1:0] react_cnt_q, react_cnt_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [2:0]    mole_pos_q, mole_pos_d;
    logic          mole_valid_q, mole_valid_d;
    logic [7:0]    hits_sent_q, hits_sent_d;
    logic          game_running_q, game_running_d;
    logic          game_over_q, game_over_d;
    logic          bad_byte_q, bad_byte_d;
    logic          restart_due;

    logic is_mole, is_over, is_bad;
    assign is_mole = rx_ready && (rx_data >= 8'h30) && (rx_data <= 8'h34);
    assign is_over = rx_ready && (rx_data == BYTE_OVER);
    assign is_bad  = rx_ready && !is_mole && !is_over;

`ifdef AUTO_RESTART_EN
    localparam int SW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
    localparam logic [SW-1:0] RESTART_LOAD = SW'(RESTART_CYCLES - 1);

    logic [SW-1:0] restart_cnt_q, restart_cnt_d;

    always_comb begin
        restart_cnt_d = restart_cnt_q;
        if (state_d == ST_DONE && state_q != ST_DONE)
            restart_cnt_d = RESTART_LOAD;
        else if (state_q == ST_DONE && restart_cnt_q != '0)
            restart_cnt_d = restart_cnt_q - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) restart_cnt_q <= '0;
        else        restart_cnt_q <= restart_cnt_d;
    end

    assign restart_due = (state_q == ST_DONE) && (restart_cnt_q == '0);
`else
    assign restart_due = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        react_cnt_d    = react_cnt_q;
        tx_start_d     = 1'b0;
        tx_data_d      = tx_data_q;
        mole_pos_d     = mole_pos_q;
        mole_valid_d   = mole_valid_q;
        hits_sent_d    = hits_sent_q;
        game_running_d = game_running_q;
        game_over_d    = 1'b0;
        bad_byte_d     = is_bad && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_req || restart_due) begin
                    state_d      = ST_SEND_START;
                    hits_sent_d  = 8'd0;
                    mole_valid_d = 1'b0;
                end
            end
            ST_SEND_START, ST_WAIT_MOLE, ST_REACT, ST_SEND_HIT: begin
                // Game over wins over any send or reload due in the same cycle
                if (is_over) begin
                    state_d        = ST_DONE;
                    game_over_d    = 1'b1;
                    game_running_d = 1'b0;
                    mole_valid_d   = 1'b0;
                end else if (state_q == ST_SEND_START) begin
                    if (!tx_busy) begin
                        tx_start_d     = 1'b1;
                        tx_data_d      = BYTE_START;
                        game_running_d = 1'b1;
                        state_d        = ST_WAIT_MOLE;
                    end
                end else if (state_q == ST_SEND_HIT) begin
                    if (is_mole) mole_pos_d = rx_data[2:0];
                    if (!tx_busy) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = BYTE_HIT;
                        if (hits_sent_q != 8'hFF) hits_sent_d = hits_sent_q + 8'd1;
                        state_d    = ST_WAIT_MOLE;
                    end
                end else if (is_mole) begin
                    mole_pos_d   = rx_data[2:0];
                    mole_valid_d = 1'b1;
                    react_cnt_d  = REACT_LOAD;
                    state_d      = ST_REACT;
                end else if (state_q == ST_REACT) begin
                    if (react_cnt_q == '0) state_d = ST_SEND_HIT;
                    else                   react_cnt_d = react_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            react_cnt_q    <= '0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= 8'h00;
            mole_pos_q     <= 3'd0;
            mole_valid_q   <= 1'b0;
            hits_sent_q    <= 8'd0;
            game_running_q <= 1'b0;
            game_over_q    <= 1'b0;
            bad_byte_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            react_cnt_q    <= react_cnt_d;
            tx_start_q     <= tx_start_d;
            tx_data_q      <= tx_data_d;
            mole_pos_q     <= mole_pos_d;
            mole_valid_q   <= mole_valid_d;
            hits_sent_q    <= hits_sent_d;
            game_running_q <= game_running_d;
            game_over_q    <= game_over_d;
            bad_byte_q     <= bad_byte_d;
        end
    end

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign mole_pos     = mole_pos_q;
    assign mole_valid   = mole_valid_q;
    assign hits_sent    = hits_sent_q;
    assign game_running = game_running_q;
    assign game_over    = game_over_q;
    assign bad_byte     = bad_byte_q;

endmodule

// File: tb/tb_mole_host_responder.sv
// Scoreboard bench for mole_host_responder: expected tx bytes, game_over and bad_byte pulses are queued with their cycle.
module tb_mole_host_responder;

    localparam int R  = 4;
    localparam int RS = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_req = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [2:0] mole_pos;
    logic       mole_valid;
    logic [7:0] hits_sent;
    logic       game_running;
    logic       game_over;
    logic       bad_byte;

    mole_host_responder #(.REACT_CYCLES(R), .RESTART_CYCLES(RS)) dut (
        .clock(clock), .reset(reset), .start_req(start_req),
        .rx_data(rx_data), .rx_ready(rx_ready), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .mole_pos(mole_pos),
        .mole_valid(mole_valid), .hits_sent(hits_sent),
        .game_running(game_running), .game_over(game_over), .bad_byte(bad_byte)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] val;
    } ev_t;

    ev_t exp_tx[$];
    int  exp_go[$];
    int  exp_bad[$];
    int  tests = 0;
    int  fails = 0;
    int  tx_seen = 0;
    ev_t mon_ev;
    int  mon_at;

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d", name, act, act, req, req, cyc);
        end
    endtask

    task automatic push_tx(int at, logic [7:0] v);
        ev_t e;
        e.at  = at;
        e.val = v;
        exp_tx.push_back(e);
    endtask

    // Monitor: pops and compares whenever the DUT presents a pulse
    always @(negedge clock) begin
        if (reset) begin
            if (tx_start) begin
                tx_seen++;
                check("tx_while_busy", int'(tx_busy), 0);
                if (exp_tx.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, expected no tx_start, cycle %0d", tx_data, cyc);
                end else begin
                    mon_ev = exp_tx.pop_front();
                    check("tx_byte", int'(tx_data), int'(mon_ev.val));
                    check("tx_cycle", cyc, mon_ev.at);
                end
            end
            if (game_over) begin
                if (exp_go.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL game_over_unexpected: got pulse, expected none, cycle %0d", cyc);
                end else begin
                    mon_at = exp_go.pop_front();
                    check("game_over_cycle", cyc, mon_at);
                end
            end
            if (bad_byte) begin
                if (exp_bad.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bad_byte_unexpected: got pulse, expected none, cycle %0d", cyc);
                end else begin
                    mon_at = exp_bad.pop_front();
                    check("bad_byte_cycle", cyc, mon_at);
                end
            end
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) begin
            @(negedge clock);
            start_req = 1'b0;
            rx_ready  = 1'b0;
        end
    endtask

    task automatic do_start();
        push_tx(cyc + 2, 8'h53);
        start_req = 1'b1;
        wait_cyc(1);
    endtask

    task automatic do_rx(logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        wait_cyc(1);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_tx_start"}, int'(tx_start), 0);
        check({tag, "_tx_data"}, int'(tx_data), 0);
        check({tag, "_mole_pos"}, int'(mole_pos), 0);
        check({tag, "_mole_valid"}, int'(mole_valid), 0);
        check({tag, "_hits"}, int'(hits_sent), 0);
        check({tag, "_running"}, int'(game_running), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
        check({tag, "_bad_byte"}, int'(bad_byte), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, idx, gap, d, nh, lastpos, k, txb;
        logic acc, next_acc;
        logic [7:0] bads [8];
        bads = '{8'h78, 8'h00, 8'h2F, 8'h35, 8'h53, 8'h48, 8'hFF, 8'h51};

        wait_cyc(3);
        check_all_zero("reset");
        reset = 1'b1;
        wait_cyc(2);

        // Start a game
        t = cyc;
        do_start();
        wait_cyc(1);
        check("start_running", int'(game_running), 1);
        check("start_hits", int'(hits_sent), 0);
        check("start_mole_valid", int'(mole_valid), 0);

        // Single mole, hit after the reaction delay
        t = cyc;
        push_tx(t + R + 2, 8'h48);
        do_rx(8'h33);
        check("mole3_pos", int'(mole_pos), 3);
        check("mole3_valid", int'(mole_valid), 1);
        wait_cyc(R + 2);
        check("mole3_hits", int'(hits_sent), 1);

        // Second mole during the reaction restarts it: one hit only
        t = cyc;
        push_tx(t + 2 + R + 2, 8'h48);
        do_rx(8'h32);
        wait_cyc(1);
        do_rx(8'h34);
        wait_cyc(R + 3);
        check("restart_pos", int'(mole_pos), 4);
        check("restart_hits", int'(hits_sent), 2);

        // Busy UART across the hit point
        t = cyc;
        do_rx(8'h31);
        tx_busy = 1'b1;
        wait_cyc(20);
        tx_busy = 1'b0;
        push_tx(t + 22, 8'h48);
        wait_cyc(3);
        check("busy_hits", int'(hits_sent), 3);

        // Game over during REACT abandons the hit; DONE ignores moles and 'R'
        t = cyc;
        do_rx(8'h30);
        wait_cyc(1);
        exp_go.push_back(t + 3);
        do_rx(8'h52);
        check("over_running", int'(game_running), 0);
        check("over_valid", int'(mole_valid), 0);
        wait_cyc(3);
        do_rx(8'h31);
        check("done_pos_held", int'(mole_pos), 0);
        check("done_hits_held", int'(hits_sent), 3);
        do_rx(8'h52);

        // Unrecognised bytes while running, including the bytes next to the mole range
        do_start();
        wait_cyc(1);
        foreach (bads[i]) begin
            if (i < 4) begin
                exp_bad.push_back(cyc + 1);
                do_rx(bads[i]);
            end
        end
        check("bad_running", int'(game_running), 1);
        check("bad_valid", int'(mole_valid), 0);
        exp_go.push_back(cyc + 1);
        do_rx(8'h52);

        // Randomized games against the timing-rule model
        for (int g = 0; g < 25; g++) begin
            wait_cyc(1);
            do_start();
            wait_cyc(1);
            nh = 0;
            acc = 1'b1;
            lastpos = 0;
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) begin
                idx = $urandom_range(0, 4);
                t = cyc;
                do_rx(8'(8'h30 + idx));
                lastpos = idx;
                if (i < k - 1) begin
                    gap = $urandom_range(1, R + 3);
                    if (acc && gap >= R + 1) begin
                        push_tx(t + R + 2, 8'h48);
                        nh++;
                    end
                    next_acc = !(acc && gap == R + 1);
                    if (gap >= 3 && $urandom_range(0, 1) == 1) begin
                        exp_bad.push_back(cyc + 1);
                        do_rx(bads[$urandom_range(0, 7)]);
                        wait_cyc(gap - 2);
                    end else begin
                        wait_cyc(gap - 1);
                    end
                    acc = next_acc;
                end else begin
                    d = $urandom_range(1, R + 4);
                    if (acc && d >= R + 2) begin
                        push_tx(t + R + 2, 8'h48);
                        nh++;
                    end
                    wait_cyc(d - 1);
                    exp_go.push_back(cyc + 1);
                    do_rx(8'h52);
                end
            end
            check("rand_hits", int'(hits_sent), nh);
            check("rand_pos", int'(mole_pos), lastpos);
            check("rand_running", int'(game_running), 0);
        end

        // Hit counter saturation
        wait_cyc(1);
        do_start();
        wait_cyc(1);
        for (int i = 0; i < 260; i++) begin
            push_tx(cyc + R + 2, 8'h48);
            do_rx(8'(8'h30 + (i % 5)));
            wait_cyc(R + 1);
        end
        exp_go.push_back(cyc + 1);
        do_rx(8'h52);
        check("sat_hits", int'(hits_sent), 255);

`ifdef AUTO_RESTART_EN
        wait_cyc(1);
        do_start();
        wait_cyc(1);
        push_tx(cyc + R + 2, 8'h48);
        do_rx(8'h32);
        wait_cyc(R + 2);
        t = cyc;
        exp_go.push_back(t + 1);
        push_tx(t + RS + 2, 8'h53);
        do_rx(8'h52);
        wait_cyc(RS + 2);
        check("auto_hits", int'(hits_sent), 0);
        check("auto_running", int'(game_running), 1);
        exp_go.push_back(cyc + 1);
        do_rx(8'h52);
`endif

        // Reset in the middle of REACT
        wait_cyc(1);
        do_start();
        wait_cyc(1);
        push_tx(cyc + R + 2, 8'h48);
        do_rx(8'h34);
        wait_cyc(R + 2);
        do_rx(8'h31);
        wait_cyc(1);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        wait_cyc(2);
        reset = 1'b1;
        txb = tx_seen;
        wait_cyc(100);
        check("midreset_no_tx", tx_seen - txb, 0);
        check("midreset_running", int'(game_running), 0);

        check("left_tx", exp_tx.size(), 0);
        check("left_game_over", exp_go.size(), 0);
        check("left_bad_byte", exp_bad.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mole_host_responder.md
# mole_host_responder

Synthesizable host-side peer of the whack-a-mole UART protocol: it plays the PC's role in hardware. It decodes the game board's byte stream ('0'..'4' mole index, 'R' game over), sends 'S' to start a game, and answers each mole with one 'H' after a fixed reaction delay. It connects between a `uart_rx`/`uart_tx` pair wired crosswise to the game board, and is used for board-to-board soak tests and self-playing demos.

## Interface
- `REACT_CYCLES`, default 25_000_000: clocks from mole byte to hit request (250 ms at 100 MHz). Legal range is ≥1.
- `RESTART_CYCLES`, default 200_000_000: DONE-to-restart delay. Used only with AUTO_RESTART_EN. Legal range is ≥1.
- `clock`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low.
- `start_req`  in  1  one-cycle pulse that requests a game start.
- `rx_data`  in  8  received byte. Valid only while `rx_ready`=1.
- `rx_ready`  in  1  one-cycle strobe from `uart_rx`.
- `tx_busy`  in  1  high while `uart_tx` is shifting.
- `tx_start`  out  1  one-cycle send request to `uart_tx`. Registered.
- `tx_data`  out  8  byte to send. Registered. Held from `tx_start` until the next `tx_start`.
- `mole_pos`  out  3  last received mole index, 0..4.
- `mole_valid`  out  1  a mole index has been received in the current game.
- `hits_sent`  out  8  count of 'H' bytes sent this game. Saturates at 255.
- `game_running`  out  1  high from the 'S' send until 'R' is received.
- `game_over`  out  1  one-cycle pulse on accepted 'R'.
- `bad_byte`  out  1  one-cycle pulse on an unrecognised byte.

## Operation
- **Reset values:** state IDLE; all outputs 0; `tx_data`=0x00; counters 0.
- **States:** IDLE, SEND_START, WAIT_MOLE, REACT, SEND_HIT, DONE.
- **Byte decode:** 0x30..0x34 is a mole byte with index = byte−0x30. 0x52 ('R') is game over. Any other byte pulses `bad_byte` for one cycle and does not change state.
- **IDLE:**
  - `start_req` moves to SEND_START.
  - All rx bytes are ignored (no `bad_byte` for 'R' or mole bytes).
- **SEND_START:**
  - On entry, clear `hits_sent` and `mole_valid`.
  - In the first cycle with `tx_busy`=0, issue `tx_start` with `tx_data`=0x53, set `game_running`=1, and move to WAIT_MOLE.
- **WAIT_MOLE and REACT, on a mole byte:**
  - Load `mole_pos` and set `mole_valid`=1.
  - Load the reaction counter with REACT_CYCLES−1 and move to REACT.
  - A new mole byte in REACT restarts the counter, so one mole produces at most one hit.
- **REACT:** decrement the counter; when it reaches 0, move to SEND_HIT.
- **SEND_HIT:**
  - In the first cycle with `tx_busy`=0, issue `tx_start` with 0x48, increment `hits_sent` (saturating), and move to WAIT_MOLE.
  - A mole byte arriving here updates `mole_pos` only; the pending hit is still sent and the state is unchanged.
- **'R' in any state except IDLE/DONE:**
  - Pulse `game_over`; clear `game_running` and `mole_valid`; move to DONE.
  - Any pending 'S' or 'H' is abandoned.
  - 'R' has priority over a `tx_start` due in the same cycle; no `tx_start` is issued.
- **DONE:**
  - `start_req` moves to SEND_START. `hits_sent` and `mole_pos` are held until then.
  - Mole bytes and 'R' are ignored.
- **`start_req` in SEND_START, WAIT_MOLE, REACT or SEND_HIT:** ignored.
- At most one `tx_start` per `tx_busy` low period. `tx_start` is never asserted while `tx_busy`=1.

## Timing
- `rx_ready` in cycle N with a mole byte: `mole_pos`/`mole_valid` update at N+1 and the state is REACT at N+1.
- The state is SEND_HIT at N+REACT_CYCLES+1.
- `tx_start`('H') is asserted at N+REACT_CYCLES+2 when `tx_busy`=0; otherwise 1 cycle after `tx_busy` falls.
- `start_req` at N with `tx_busy`=0: `tx_start`('S') at N+2 and `game_running`=1 at N+2.
- 'R' at N: `game_over` is high in cycle N+1 only.
- Asynchronous reset mid-transfer drops `tx_start` immediately. `uart_tx` is reset by the same net.

## Configuration
- **`AUTO_RESTART_EN` defined:**
  - On entry to DONE, load the restart counter with RESTART_CYCLES−1.
  - At 0, move to SEND_START without `start_req`.
  - `start_req` in DONE still restarts immediately and cancels the counter.
- **Undefined:** the restart counter is not built, and DONE waits for `start_req` indefinitely.

## Test plan
- Assert reset mid-REACT → all outputs 0, state IDLE, no `tx_start` for 100 cycles.
- `start_req` pulse, `tx_busy`=0 → exactly one `tx_start` with `tx_data`=0x53 two cycles later; `game_running`=1; `hits_sent`=0.
- REACT_CYCLES=4; rx 0x33 at cycle N → `mole_pos`=3 at N+1; one `tx_start` with 0x48 at N+6; `hits_sent`=1.
- REACT_CYCLES=4; rx 0x32 at N, 0x34 at N+2 → single 'H' at N+8; `mole_pos`=4.
- Hold `tx_busy`=1 for 20 cycles across the hit point → `tx_start` is asserted once, one cycle after `tx_busy` falls. Then rx 0x52 during REACT → `game_over` pulse, no 'H', state DONE.
- Rx 0x78 while `game_running` → `bad_byte` pulse with no state change. With AUTO_RESTART_EN and RESTART_CYCLES=8: after 'R', 0x53 is resent 10 cycles later and `hits_sent` returns to 0.
